vpu_video_rx: RTL and testbench
===============================

# vpu_video_rx

Video-stream receiver for the VPU output (`dot_clk`, `color`, `hsync`, `vsync`). It recovers pixel coordinates from the sync pulses and writes each active pixel into a frame-capture memory through a single BRAM write port. It also reports frame completion and timing violations. It sits beside `vpu_core` in the `clk` domain and is used for framebuffer dump, display bridging and self-check of VPU timing.

## Interface
Parameters:
- `H_ACTIVE`, default `SCREEN_W`: captured dots per line.
- `V_ACTIVE`, default `SCREEN_H`: captured lines per frame.
- `H_TOTAL`, default `SCREEN_W+SCREEN_HBLANK`: expected dots per line.
- `V_TOTAL`, default `SCREEN_H+SCREEN_VBLANK`: expected lines per frame.
- `H_START`, default 0: first captured dot index after the hsync assertion dot.
- `V_START`, default 0: first captured line index after the vsync assertion line.
- `SYNC_POL`, default 1'b1: active level of `hsync` and `vsync`.
- `FB_ADDR_W`, default 17: frame-memory address width.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `dot_clk`  in  1  pixel strobe, generated in the `clk` domain.
- `color`  in  32  pixel data.
- `hsync`  in  1  line sync.
- `vsync`  in  1  frame sync.
- `capture_en`  in  1  level: capture frames while high.
- `err_clr`  in  1  pulse: clear the sticky error flags.
- `fb_we`  out  1  frame-memory write enable.
- `fb_addr`  out  FB_ADDR_W  write address.
- `fb_din`  out  32  write data.
- `frame_done`  out  1  1-cycle pulse when the last pixel of a frame is written.
- `frame_count`  out  16  count of completed frames, wraps.
- `busy`  out  1  high in ARM or CAPTURE.
- `line_len_err`  out  1  sticky flag: a line did not have H_TOTAL dots.
- `frame_len_err`  out  1  sticky flag: a frame did not have V_TOTAL lines.

## Operation
- Stage 1 registers all four inputs. A dot event (`dot_ev`) is `dot_q & ~dot_q2`. All logic below advances only on `dot_ev` and uses the registered `color`, `hsync` and `vsync`.
- An hsync edge (`hs_edge`) is when `hsync` equals `SYNC_POL` at this dot and did not at the previous dot. A vsync edge (`vs_edge`) is defined the same way.
- Dot counter `x` (11 bits):
  - `hs_edge` sets `x` to 0.
  - Otherwise `x` increments and saturates at 2047.
- Line counter `y` (10 bits):
  - `vs_edge` sets `y` to 0.
  - Otherwise, `hs_edge` increments `y`, saturating.
  - When `hs_edge` and `vs_edge` occur on the same dot, `x` = 0 and `y` = 0.
- A dot is active when H_START ≤ `x` < H_START+H_ACTIVE and V_START ≤ `y` < V_START+V_ACTIVE.
- `fb_addr` = (`y`−V_START)·H_ACTIVE + (`x`−H_START), truncated to FB_ADDR_W.
- State machine:
  - IDLE: no writes; counters keep tracking. `capture_en`=1 moves to ARM.
  - ARM: waits for `vs_edge`, then moves to CAPTURE. That same dot is already a capture dot. `capture_en`=0 returns to IDLE.
  - CAPTURE: every active dot is written. On each `vs_edge`, stay in CAPTURE if `capture_en`=1, otherwise go to IDLE. Dropping `capture_en` mid-frame therefore finishes the current frame.
- Error checks, made only in CAPTURE:
  - On `hs_edge`: if the previous `x`+1 ≠ H_TOTAL, set `line_len_err`. The first `hs_edge` after entering CAPTURE is not checked.
  - On `vs_edge`: if the previous `y`+1 ≠ V_TOTAL, set `frame_len_err`.
- Error flags clear on `err_clr` or reset. If a new error and `err_clr` occur in the same cycle, the set wins.
- `frame_done` pulses together with the `fb_we` of the dot (H_START+H_ACTIVE−1, V_START+V_ACTIVE−1). `frame_count` increments on that same cycle.
- Reset mid-frame returns to IDLE with all counters zeroed. No write is issued after the reset edge.

## Timing
- Reset values:
  - `fb_we`, `fb_addr`, `fb_din`, `frame_done`, `frame_count`, `busy` and both error flags: 0.
  - State: IDLE.
  - `x`, `y` and the input registers: 0.
- Latency: `fb_we` is asserted on the 2nd rising `clk` edge after the first edge that samples `dot_clk`=1. It lasts exactly 1 cycle per dot, whatever the `dot_clk` high time.
- `fb_addr` and `fb_din` are valid only while `fb_we`=1. Otherwise they hold their last values.
- `busy` is registered and changes 1 cycle after the state transition.
- No back-pressure: the memory accepts one write per cycle. Minimum dot period is 2 `clk` cycles.

## Structure
- Shared package `gameconsole_pkg` holds:
  - `SCREEN_W`, `SCREEN_H`, `SCREEN_HBLANK`, `SCREEN_VBLANK` (existing).
  - New `FB_ADDR_W` and `FB_DATA_W`.
  - A typedef `vrx_state_t` with values IDLE/ARM/CAPTURE.
- One sub-module, `vpu_sync_edge`: input registering, `dot_ev` generation and polarity-aware sync edge detection.
- The counters, state machine and write port stay in `vpu_video_rx`.

## Test plan
All scenarios use H_ACTIVE=4, H_TOTAL=6, V_ACTIVE=3, V_TOTAL=5, `dot_clk` high 1 cycle out of 4, and `color` = {y,x}.
- Nominal frame with `capture_en`=1 from reset: 12 writes, addresses 0..11, `fb_din` at address 5 = {1,1}. `frame_done` coincides with address 11; `frame_count`=1; no errors.
- H_START=1, V_START=1: the first write has address 0 with data {1,1}; no write occurs for `x`=0 or `y`=0.
- Line of 7 dots inside a captured frame: `line_len_err`=1 at the next `hs_edge`, stays set, and clears after `err_clr`.
- `capture_en` dropped at address 3: the frame completes through address 11, then the block enters IDLE and the next frame produces no writes; `busy`=0.
- Frame of 4 lines: `frame_len_err`=1 at `vs_edge`. Coincident `hs_edge`/`vs_edge` gives `x`=0, `y`=0, and the next write has address 0.
- Reset asserted at address 6: no `fb_we` afterwards and all outputs 0. A resumed stream with `capture_en`=1 captures from the next `vs_edge`.

Source files
------------

// File: rtl/gameconsole_pkg.sv
// Shared console constants and types: screen geometry, frame-memory widths
// and the video receiver state encoding.
package gameconsole_pkg;

  localparam int SCREEN_W      = 320;
  localparam int SCREEN_H      = 240;
  localparam int SCREEN_HBLANK = 80;
  localparam int SCREEN_VBLANK = 20;

  localparam int FB_ADDR_W = 17;
  localparam int FB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2
  } vrx_state_t;

endpackage

// File: rtl/vpu_sync_edge.sv
// Input registering for the VPU video stream: one dot event per dot_clk rising
// edge, plus sync edges in the active polarity sampled at dot events only.
module vpu_sync_edge #(
  parameter logic SYNC_POL = 1'b1,
  parameter int   DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dot_clk_i,
  input  logic [DATA_W-1:0] color_i,
  input  logic              hsync_i,
  input  logic              vsync_i,
  output logic              dot_ev_o,
  output logic              hs_edge_o,
  output logic              vs_edge_o,
  output logic [DATA_W-1:0] color_o
);

  logic              dot_q, dot_q2, hs_q, vs_q;
  logic              hs_prev_q, vs_prev_q;
  logic [DATA_W-1:0] color_q;
  logic              hs_act_s, vs_act_s;

  // Input stage plus the sync level seen at the previous dot
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot_q     <= 1'b0;
      dot_q2    <= 1'b0;
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      color_q   <= '0;
      hs_prev_q <= 1'b0;
      vs_prev_q <= 1'b0;
    end else begin
      dot_q   <= dot_clk_i;
      dot_q2  <= dot_q;
      hs_q    <= hsync_i;
      vs_q    <= vsync_i;
      color_q <= color_i;
      if (dot_ev_o) begin
        hs_prev_q <= hs_act_s;
        vs_prev_q <= vs_act_s;
      end else begin
        hs_prev_q <= hs_prev_q;
        vs_prev_q <= vs_prev_q;
      end
    end
  end

  // Dot strobe and polarity-aware edge detection
  always_comb begin
    hs_act_s  = (hs_q == SYNC_POL);
    vs_act_s  = (vs_q == SYNC_POL);
    dot_ev_o  = dot_q & ~dot_q2;
    hs_edge_o = dot_ev_o & hs_act_s & ~hs_prev_q;
    vs_edge_o = dot_ev_o & vs_act_s & ~vs_prev_q;
    color_o   = color_q;
  end

endmodule

// File: rtl/vpu_video_rx.sv
// VPU video-stream receiver: recovers pixel coordinates from sync pulses,
// writes active pixels to frame memory and flags line/frame length errors.
module vpu_video_rx #(
  parameter int   H_ACTIVE  = gameconsole_pkg::SCREEN_W,
  parameter int   V_ACTIVE  = gameconsole_pkg::SCREEN_H,
  parameter int   H_TOTAL   = gameconsole_pkg::SCREEN_W + gameconsole_pkg::SCREEN_HBLANK,
  parameter int   V_TOTAL   = gameconsole_pkg::SCREEN_H + gameconsole_pkg::SCREEN_VBLANK,
  parameter int   H_START   = 0,
  parameter int   V_START   = 0,
  parameter logic SYNC_POL  = 1'b1,
  parameter int   FB_ADDR_W = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dot_clk,
  input  logic [31:0]          color,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic                 capture_en,
  input  logic                 err_clr,
  output logic                 fb_we,
  output logic [FB_ADDR_W-1:0] fb_addr,
  output logic [31:0]          fb_din,
  output logic                 frame_done,
  output logic [15:0]          frame_count,
  output logic                 busy,
  output logic                 line_len_err,
  output logic                 frame_len_err
);

  import gameconsole_pkg::*;

  logic                 dot_ev_s, hs_edge_s, vs_edge_s;
  logic [31:0]          color_s;
  vrx_state_t           state_q, state_d;
  logic [10:0]          x_q, x_d;
  logic [9:0]           y_q, y_d;
  logic                 cap_q, cap_d, skip_q, skip_d;
  logic [31:0]          pix_q;
  logic                 line_err_q, line_err_d, frame_err_q, frame_err_d;
  logic                 active_s, last_s;
  logic [FB_ADDR_W-1:0] addr_s;
  logic                 fb_we_q, frame_done_q, busy_q;
  logic [FB_ADDR_W-1:0] fb_addr_q;
  logic [31:0]          fb_din_q;
  logic [15:0]          frame_count_q;

  vpu_sync_edge #(
    .SYNC_POL (SYNC_POL),
    .DATA_W   (32)
  ) u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .dot_clk_i (dot_clk),
    .color_i   (color),
    .hsync_i   (hsync),
    .vsync_i   (vsync),
    .dot_ev_o  (dot_ev_s),
    .hs_edge_o (hs_edge_s),
    .vs_edge_o (vs_edge_s),
    .color_o   (color_s)
  );

  // Capture state machine next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture_en) state_d = ARM; else state_d = IDLE;
      ARM:     if (!capture_en) state_d = IDLE;
               else if (vs_edge_s) state_d = CAPTURE;
               else state_d = ARM;
      CAPTURE: if (vs_edge_s && !capture_en) state_d = IDLE; else state_d = CAPTURE;
      default: state_d = IDLE;
    endcase
  end

  // Coordinate counters, pending-pixel flag and sticky length checks
  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    skip_d      = skip_q;
    line_err_d  = line_err_q;
    frame_err_d = frame_err_q;
    cap_d       = dot_ev_s && (state_d == CAPTURE);
    if (dot_ev_s) begin
      if (hs_edge_s) x_d = 11'd0;
      else if (x_q != 11'h7FF) x_d = x_q + 11'd1;
      else x_d = x_q;
      if (vs_edge_s) y_d = 10'd0;
      else if (hs_edge_s && (y_q != 10'h3FF)) y_d = y_q + 10'd1;
      else y_d = y_q;
    end else begin
      x_d = x_q;
      y_d = y_q;
    end
    // The entry line is only partially observed unless capture starts on an hsync edge
    if (state_q == ARM && state_d == CAPTURE) skip_d = ~hs_edge_s;
    else if (state_q == CAPTURE && hs_edge_s) skip_d = 1'b0;
    else skip_d = skip_q;
    if (state_q == CAPTURE && hs_edge_s && !skip_q &&
        ({21'd0, x_q} + 32'd1 != 32'(H_TOTAL))) line_err_d = 1'b1;
    else if (err_clr) line_err_d = 1'b0;
    else line_err_d = line_err_q;
    if (state_q == CAPTURE && vs_edge_s &&
        ({22'd0, y_q} + 32'd1 != 32'(V_TOTAL))) frame_err_d = 1'b1;
    else if (err_clr) frame_err_d = 1'b0;
    else frame_err_d = frame_err_q;
  end

  // Write-stage decode of the pending dot
  always_comb begin
    active_s = cap_q &&
               ({21'd0, x_q} >= 32'(H_START)) && ({21'd0, x_q} < 32'(H_START + H_ACTIVE)) &&
               ({22'd0, y_q} >= 32'(V_START)) && ({22'd0, y_q} < 32'(V_START + V_ACTIVE));
    last_s   = ({21'd0, x_q} == 32'(H_START + H_ACTIVE - 1)) &&
               ({22'd0, y_q} == 32'(V_START + V_ACTIVE - 1));
    addr_s   = FB_ADDR_W'(({22'd0, y_q} - 32'(V_START)) * 32'(H_ACTIVE) +
                          ({21'd0, x_q} - 32'(H_START)));
  end

  // State, counters, error flags and the registered write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      x_q           <= 11'd0;
      y_q           <= 10'd0;
      cap_q         <= 1'b0;
      skip_q        <= 1'b0;
      pix_q         <= 32'd0;
      line_err_q    <= 1'b0;
      frame_err_q   <= 1'b0;
      fb_we_q       <= 1'b0;
      fb_addr_q     <= '0;
      fb_din_q      <= 32'd0;
      frame_done_q  <= 1'b0;
      frame_count_q <= 16'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      cap_q        <= cap_d;
      skip_q       <= skip_d;
      pix_q        <= dot_ev_s ? color_s : pix_q;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      fb_we_q      <= active_s;
      frame_done_q <= active_s && last_s;
      busy_q       <= (state_q != IDLE);
      if (active_s) begin
        fb_addr_q <= addr_s;
        fb_din_q  <= pix_q;
      end else begin
        fb_addr_q <= fb_addr_q;
        fb_din_q  <= fb_din_q;
      end
      if (active_s && last_s) frame_count_q <= frame_count_q + 16'd1;
      else frame_count_q <= frame_count_q;
    end
  end

  assign fb_we         = fb_we_q;
  assign fb_addr       = fb_addr_q;
  assign fb_din        = fb_din_q;
  assign frame_done    = frame_done_q;
  assign frame_count   = frame_count_q;
  assign busy          = busy_q;
  assign line_len_err  = line_err_q;
  assign frame_len_err = frame_err_q;

endmodule

// File: tb/tb_vpu_video_rx.sv
// Directed bench for vpu_video_rx: a 6x5 dot stream (4x3 active) drives a
// zero-offset instance (a_*) and a one-dot/one-line offset instance (b_*).
module tb_vpu_video_rx;

  logic        clk = 1'b0, rst_n = 1'b0, dot_clk = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic        capture_en = 1'b0, err_clr = 1'b0;
  logic [31:0] color = 32'd0;

  logic        a_fb_we, a_frame_done, a_busy, a_line_err, a_frame_err;
  logic [16:0] a_fb_addr;
  logic [31:0] a_fb_din;
  logic [15:0] a_frame_count;
  logic        b_fb_we, b_frame_done, b_busy, b_line_err, b_frame_err;
  logic [16:0] b_fb_addr;
  logic [31:0] b_fb_din;
  logic [15:0] b_frame_count;

  int          total = 0, bad = 0;
  int          a_addr_q[$], b_addr_q[$];
  logic [31:0] a_din_q[$], b_din_q[$];
  int          a_fd_cnt = 0;
  logic [3:0]  we_pat;

  vpu_video_rx #(.H_ACTIVE(4), .V_ACTIVE(3), .H_TOTAL(6), .V_TOTAL(5),
                 .H_START(0), .V_START(0), .SYNC_POL(1'b1), .FB_ADDR_W(17)) u_dut (
    .clk(clk), .rst_n(rst_n), .dot_clk(dot_clk), .color(color), .hsync(hsync),
    .vsync(vsync), .capture_en(capture_en), .err_clr(err_clr), .fb_we(a_fb_we),
    .fb_addr(a_fb_addr), .fb_din(a_fb_din), .frame_done(a_frame_done),
    .frame_count(a_frame_count), .busy(a_busy), .line_len_err(a_line_err),
    .frame_len_err(a_frame_err));

  vpu_video_rx #(.H_ACTIVE(4), .V_ACTIVE(3), .H_TOTAL(6), .V_TOTAL(5),
                 .H_START(1), .V_START(1), .SYNC_POL(1'b1), .FB_ADDR_W(17)) u_dut_ofs (
    .clk(clk), .rst_n(rst_n), .dot_clk(dot_clk), .color(color), .hsync(hsync),
    .vsync(vsync), .capture_en(capture_en), .err_clr(err_clr), .fb_we(b_fb_we),
    .fb_addr(b_fb_addr), .fb_din(b_fb_din), .frame_done(b_frame_done),
    .frame_count(b_frame_count), .busy(b_busy), .line_len_err(b_line_err),
    .frame_len_err(b_frame_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_fb_we) begin
      a_addr_q.push_back(int'(a_fb_addr));
      a_din_q.push_back(a_fb_din);
    end
    if (a_frame_done) a_fd_cnt++;
    if (b_fb_we) begin
      b_addr_q.push_back(int'(b_fb_addr));
      b_din_q.push_back(b_fb_din);
    end
  end

  task automatic clear_logs();
    a_addr_q.delete(); a_din_q.delete(); b_addr_q.delete(); b_din_q.delete();
    a_fd_cnt = 0;
  endtask

  // One dot: dot_clk high for 1 of 4 cycles; we_pat[i] is fb_we 1ns after edge i+1
  task automatic send_dot(input int x, input int y, input bit hs, input bit vs);
    dot_clk = 1'b1; hsync = hs; vsync = vs; color = {16'(y), 16'(x)};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) dot_clk = 1'b0;
      we_pat[i] = a_fb_we;
    end
  endtask

  task automatic send_line(input int y, input int x0, input int ndots, input bit vs);
    for (int x = x0; x < ndots; x++) send_dot(x, y, (x == 0), vs);
  endtask

  task automatic send_frame(input int nlines);
    for (int y = 0; y < nlines; y++) send_line(y, 0, 6, (y == 0));
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1; @(posedge clk); #1; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({a_fb_we, a_frame_done, a_busy, a_line_err, a_frame_err} !== 5'd0) begin
      bad++; $display("FAIL reset_flags: got %b want 00000", {a_fb_we, a_frame_done, a_busy, a_line_err, a_frame_err}); end
    total++; if ({a_fb_addr, a_fb_din, a_frame_count} !== 65'd0) begin
      bad++; $display("FAIL reset_data: got %h want 0", {a_fb_addr, a_fb_din, a_frame_count}); end
    rst_n = 1'b1; capture_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL arm_busy: got %b want 1", a_busy); end
  endtask

  task automatic test_nominal();
    clear_logs();
    send_dot(0, 0, 1'b1, 1'b1);
    total++; if (we_pat !== 4'b0100) begin bad++; $display("FAIL latency: got %b want 0100", we_pat); end
    send_line(0, 1, 6, 1'b1);
    for (int y = 1; y < 5; y++) send_line(y, 0, 6, 1'b0);
    total++; if (a_addr_q.size() !== 12) begin bad++; $display("FAIL nominal_count: got %0d want 12", a_addr_q.size()); end
    for (int i = 0; i < a_addr_q.size(); i++) begin
      total++; if (a_addr_q[i] !== i) begin bad++; $display("FAIL nominal_addr[%0d]: got %0d want %0d", i, a_addr_q[i], i); end
      total++; if (a_din_q[i] !== {16'(i / 4), 16'(i % 4)}) begin
        bad++; $display("FAIL nominal_din[%0d]: got %h want %h", i, a_din_q[i], {16'(i / 4), 16'(i % 4)}); end
    end
    total++; if (a_addr_q.size() < 6 || a_din_q[5] !== {16'd1, 16'd1}) begin
      bad++; $display("FAIL nominal_din5: got entries %0d, want data 00010001 at address 5", a_addr_q.size()); end
    total++; if (a_fd_cnt !== 1) begin bad++; $display("FAIL nominal_done_cnt: got %0d want 1", a_fd_cnt); end
    total++; if (a_frame_count !== 16'd1) begin bad++; $display("FAIL nominal_frame_count: got %0d want 1", a_frame_count); end
    total++; if ({a_line_err, a_frame_err} !== 2'b00) begin bad++; $display("FAIL nominal_errs: got %b want 00", {a_line_err, a_frame_err}); end
  endtask

  task automatic test_done_alignment();
    int seen;
    seen = 0;
    send_dot(0, 0, 1'b1, 1'b1);
    send_line(0, 1, 6, 1'b1);
    send_line(1, 0, 6, 1'b0);
    send_line(2, 0, 3, 1'b0);
    // last active dot: frame_done must appear with its write, not before
    dot_clk = 1'b1; hsync = 1'b0; vsync = 1'b0; color = {16'd2, 16'd3};
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i == 0) dot_clk = 1'b0;
      if (a_frame_done) begin
        seen++;
        total++; if ({a_fb_we, int'(a_fb_addr)} !== {1'b1, 32'd11}) begin
          bad++; $display("FAIL done_align: got we=%b addr=%0d want we=1 addr=11", a_fb_we, a_fb_addr); end
      end
    end
    total++; if (seen !== 1) begin bad++; $display("FAIL done_pulses: got %0d want 1", seen); end
    send_line(2, 4, 6, 1'b0);
    send_line(3, 0, 6, 1'b0);
    send_line(4, 0, 6, 1'b0);
  endtask

  task automatic test_offset();
    clear_logs();
    send_frame(5);
    total++; if (b_addr_q.size() !== 12) begin bad++; $display("FAIL ofs_count: got %0d want 12", b_addr_q.size()); end
    total++; if (b_addr_q.size() == 0 || {b_addr_q[0], b_din_q[0]} !== {32'd0, 16'd1, 16'd1}) begin
      bad++; $display("FAIL ofs_first: got %0d entries, want address 0 data 00010001 first", b_addr_q.size()); end
    for (int i = 0; i < b_din_q.size(); i++) begin
      total++; if (b_din_q[i][15:0] == 16'd0 || b_din_q[i][31:16] == 16'd0) begin
        bad++; $display("FAIL ofs_edge_pixel[%0d]: got %h want nonzero x and y", i, b_din_q[i]); end
    end
    total++; if (a_frame_count !== 16'd3) begin bad++; $display("FAIL ofs_frame_count: got %0d want 3", a_frame_count); end
    total++; if (a_frame_err !== 1'b0) begin bad++; $display("FAIL ofs_frame_err: got %b want 0", a_frame_err); end
  endtask

  task automatic test_line_len_err();
    send_line(0, 0, 6, 1'b1);
    send_line(1, 0, 7, 1'b0);
    total++; if (a_line_err !== 1'b0) begin bad++; $display("FAIL line_err_early: got %b want 0", a_line_err); end
    send_dot(0, 2, 1'b1, 1'b0);
    total++; if (a_line_err !== 1'b1) begin bad++; $display("FAIL line_err_set: got %b want 1", a_line_err); end
    send_line(2, 1, 6, 1'b0);
    send_line(3, 0, 6, 1'b0);
    send_line(4, 0, 6, 1'b0);
    total++; if (a_line_err !== 1'b1) begin bad++; $display("FAIL line_err_sticky: got %b want 1", a_line_err); end
    pulse_err_clr();
    @(posedge clk); #1;
    total++; if (a_line_err !== 1'b0) begin bad++; $display("FAIL line_err_clr: got %b want 0", a_line_err); end
  endtask

  task automatic test_capture_drop();
    clear_logs();
    send_line(0, 0, 4, 1'b1);
    capture_en = 1'b0;
    send_line(0, 4, 6, 1'b1);
    for (int y = 1; y < 5; y++) send_line(y, 0, 6, 1'b0);
    total++; if (a_addr_q.size() !== 12) begin bad++; $display("FAIL drop_count: got %0d want 12", a_addr_q.size()); end
    total++; if (a_addr_q.size() == 0 || a_addr_q[a_addr_q.size() - 1] !== 11) begin
      bad++; $display("FAIL drop_last: got %0d entries, want last address 11", a_addr_q.size()); end
    total++; if (a_frame_count !== 16'd5) begin bad++; $display("FAIL drop_frame_count: got %0d want 5", a_frame_count); end
    clear_logs();
    send_frame(5);
    total++; if (a_addr_q.size() + b_addr_q.size() !== 0) begin
      bad++; $display("FAIL idle_writes: got %0d want 0", a_addr_q.size() + b_addr_q.size()); end
    total++; if (a_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", a_busy); end
  endtask

  task automatic test_frame_len_err();
    capture_en = 1'b1;
    clear_logs();
    send_frame(4);
    total++; if (a_addr_q.size() !== 12) begin bad++; $display("FAIL short_count: got %0d want 12", a_addr_q.size()); end
    total++; if (a_frame_err !== 1'b0) begin bad++; $display("FAIL frame_err_early: got %b want 0", a_frame_err); end
    clear_logs();
    send_dot(0, 0, 1'b1, 1'b1);
    total++; if (a_frame_err !== 1'b1) begin bad++; $display("FAIL frame_err_set: got %b want 1", a_frame_err); end
    total++; if (a_addr_q.size() == 0 || {a_addr_q[0], a_din_q[0]} !== 64'd0) begin
      bad++; $display("FAIL coincident_first: got %0d entries, want address 0 data 0", a_addr_q.size()); end
    send_line(0, 1, 6, 1'b1);
    for (int y = 1; y < 5; y++) send_line(y, 0, 6, 1'b0);
    total++; if (a_line_err !== 1'b0) begin bad++; $display("FAIL frame_err_line: got %b want 0", a_line_err); end
  endtask

  task automatic test_reset_mid();
    pulse_err_clr();
    clear_logs();
    send_line(0, 0, 6, 1'b1);
    send_line(1, 0, 2, 1'b0);
    dot_clk = 1'b1; hsync = 1'b0; vsync = 1'b0; color = {16'd1, 16'd2};
    @(posedge clk); #1;
    dot_clk = 1'b0; rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++; if (a_addr_q.size() !== 6) begin bad++; $display("FAIL rst_writes: got %0d want 6", a_addr_q.size()); end
    total++; if ({a_fb_we, a_fb_addr, a_fb_din, a_frame_done, a_frame_count, a_busy, a_line_err, a_frame_err} !== 70'd0) begin
      bad++; $display("FAIL rst_outputs_a: got %h want 0", {a_fb_we, a_fb_addr, a_fb_din, a_frame_done, a_frame_count, a_busy, a_line_err, a_frame_err}); end
    total++; if ({b_fb_we, b_fb_addr, b_fb_din, b_frame_done, b_frame_count, b_busy, b_line_err, b_frame_err} !== 70'd0) begin
      bad++; $display("FAIL rst_outputs_b: got %h want 0", {b_fb_we, b_fb_addr, b_fb_din, b_frame_done, b_frame_count, b_busy, b_line_err, b_frame_err}); end
    rst_n = 1'b1;
    send_line(1, 3, 6, 1'b0);
    for (int y = 2; y < 5; y++) send_line(y, 0, 6, 1'b0);
    total++; if (a_addr_q.size() !== 6) begin bad++; $display("FAIL rst_armed_writes: got %0d want 6", a_addr_q.size()); end
    total++; if (a_busy !== 1'b1) begin bad++; $display("FAIL rst_armed_busy: got %b want 1", a_busy); end
    clear_logs();
    send_frame(5);
    total++; if (a_addr_q.size() !== 12 || a_addr_q[0] !== 0) begin
      bad++; $display("FAIL resume_capture: got %0d entries, want 12 starting at address 0", a_addr_q.size()); end
    total++; if (a_frame_count !== 16'd1) begin bad++; $display("FAIL resume_frame_count: got %0d want 1", a_frame_count); end
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_nominal();
    test_done_alignment();
    test_offset();
    test_line_len_err();
    test_capture_drop();
    test_frame_len_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
